divider_32bit: RTL and testbench
================================

Name: divider_32bit

Overview:
- Multi-cycle iterative restoring divider for the MIPS datapath. It executes DIV and DIVU.
- It inverts the adder's job: it finds the quotient and remainder by repeated 33-bit trial subtraction, one quotient bit per clock.
- It sits beside the ALU. The control unit stalls the pipeline while busy is high and writes quotient/remainder into the LO/HI registers when done pulses.

Parameters:
- WIDTH, 32, operand/result width. The only supported value is 32; the iteration counter is sized for it.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a division. Sampled only when busy=0.
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU. Sampled with start.
- data1  input  32  dividend. Sampled with start.
- data2  input  32  divisor. Sampled with start.
- quotient  output  32  result for LO. Registered; holds until the next done.
- remainder  output  32  result for HI. Registered; holds until the next done.
- busy  output  1  high from the edge that accepts start until the edge that raises done.
- done  output  1  one-cycle pulse when quotient/remainder are valid.
- div_by_zero  output  1  flag for the most recent result.
- overflow  output  1  signed 0x80000000 / 0xFFFFFFFF occurred. Flag for the most recent result.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - state=IDLE.
  - busy, done, div_by_zero and overflow = 0.
  - quotient and remainder = 0.
  - Internal registers cleared; an in-flight operation is abandoned.
- States: IDLE, RUN, FIX.
- IDLE, edge E0 with start=1:
  - Latch is_signed.
  - Latch |data1| and |data2|: the magnitude when is_signed=1 and the operand is negative, otherwise the raw value.
  - Latch the sign of data1 (remainder sign) and the XOR of the two signs (quotient sign); both are forced to 0 when unsigned.
  - Clear the partial remainder. Count=0. busy=1.
  - If data2==0, go to FIX with the zero flag set. Otherwise go to RUN.
- RUN, one iteration per edge (E1..E32):
  - Shift {rem, dvd} left by one.
  - Compute trial = {1'b0, rem} - {1'b0, |divisor|} at 33 bits.
  - If trial[32]==0: rem = trial[31:0] and the new quotient LSB = 1. Otherwise rem is restored and the LSB = 0.
  - Count increments. After the 32nd iteration (E32), go to FIX.
- FIX, one edge (E33 for a normal run; E1 for divide-by-zero):
  - quotient = negate(qmag) if the quotient sign is set, else qmag.
  - remainder = negate(rem) if the remainder sign is set, else rem.
  - Divide-by-zero: quotient=32'hFFFFFFFF, remainder = original data1 unmodified, div_by_zero=1.
  - overflow=1 iff is_signed and data1=0x80000000 and data2=0xFFFFFFFF. In that case the natural result is quotient=0x80000000, remainder=0.
  - done=1, busy=0, state=IDLE.
- Latency:
  - done is high during the cycle after E33, i.e. 33 clocks after the accepting edge.
  - Divide-by-zero: done is high after E1, i.e. 1 clock.
- done is high for exactly one cycle. Flags update only on the edge that raises done; they are cleared at the next accepted start.
- start while busy=1 is ignored: no effect on the operation, and the operands are not re-sampled.
- start during the done cycle is accepted (busy=0 then). Back-to-back divisions therefore need no gap cycle.
- Inputs may change freely after the accepting edge; only the latched copies are used.
- Remainder magnitude is always less than the divisor magnitude. Signed results truncate toward zero (MIPS semantics).
- Negation of 0x80000000 stays 0x80000000 and is treated as magnitude 2^31 (unsigned).

Test Plan:
- Unsigned basic: DIVU 100/7 -> quotient=14, remainder=2, done exactly 33 clocks after start, busy high for those 33 cycles, flags 0.
- Signed signs:
  - -7/2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
  - 7/-2 -> quotient=0xFFFFFFFD, remainder=1.
  - -7/-2 -> quotient=3, remainder=0xFFFFFFFF.
- Boundaries:
  - DIVU 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
  - DIV 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, overflow=1.
  - DIVU 5/9 -> quotient=0, remainder=5.
- Divide-by-zero: 0x12345678/0 (signed and unsigned) -> done after 1 clock, quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1. The next valid division clears the flag.
- Handshake:
  - start with new operands pulsed at clock 5 of a run is ignored and the result matches the first operands.
  - A start in the done cycle is accepted and yields a second correct result 33 clocks later.
- Reset mid-run: assert rst asynchronously (between edges) at clock 10 of a run -> busy, done and all outputs go to 0 immediately, with no done pulse. After release, a fresh DIVU 50/5 gives quotient=10, remainder=0.

Source files
------------

// File: rtl/divider_32bit.sv
// Iterative restoring divider for DIV/DIVU: one quotient bit per clock,
// sign fix-up in a final cycle, results held until the next done pulse.
module divider_32bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend magnitude, becomes quotient magnitude
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic             zero_q, zero_d, ovf_q, ovf_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             dbz_q, dbz_d, ovfl_q, ovfl_d;
  logic [WIDTH-1:0] quo_q, quo_d, rmd_q, rmd_d;

  logic             neg1, neg2;
  logic [WIDTH:0]   partial, trial;

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    ovfl_d  = ovfl_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;

    neg1 = is_signed & data1[WIDTH-1];
    neg2 = is_signed & data2[WIDTH-1];
    // Shifted partial remainder keeps its carry-out bit, so divisors above
    // 2^31 still compare correctly.
    partial = {rem_q, dvd_q[WIDTH-1]};
    trial   = partial - {1'b0, dsr_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          zero_d  = (data2 == '0);
          // On divide-by-zero the raw dividend is kept for the remainder.
          dvd_d   = (neg1 && data2 != '0) ? -data1 : data1;
          dsr_d   = neg2 ? -data2 : data2;
          rem_d   = '0;
          cnt_d   = '0;
          qneg_d  = neg1 ^ neg2;
          rneg_d  = neg1;
          ovf_d   = is_signed && data1 == {1'b1, {(WIDTH-1){1'b0}}} && data2 == '1;
          busy_d  = 1'b1;
          dbz_d   = 1'b0;
          ovfl_d  = 1'b0;
          state_d = (data2 == '0) ? FIX : RUN;
        end
      end
      RUN: begin
        rem_d = trial[WIDTH] ? partial[WIDTH-1:0] : trial[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        if (zero_q) begin
          quo_d = '1;
          rmd_d = dvd_q;
        end else begin
          quo_d = qneg_q ? -dvd_q : dvd_q;
          rmd_d = rneg_q ? -rem_q : rem_q;
        end
        dbz_d   = zero_q;
        ovfl_d  = ovf_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovfl_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      ovfl_q  <= ovfl_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovfl_q;

endmodule

// File: tb/tb_divider_32bit.sv
// Directed bench for divider_32bit: expected results queued at start,
// compared when done pulses.
module tb_divider_32bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] data1 = '0, data2 = '0;
  logic [31:0] quotient, remainder;
  logic        busy, done, div_by_zero, overflow;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  divider_32bit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .data1(data1), .data2(data2), .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input bit s, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.dbz = 1'b0;
    e.ovf = 1'b0;
    if (b == 0) begin
      e.q = 32'hFFFF_FFFF; e.r = a; e.dbz = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000; e.r = 32'h0; e.ovf = 1'b1;
    end else if (s) begin
      e.q = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Called just after an edge; start is taken on the next edge, then operands are scrambled.
  task automatic start_op(input bit s, input logic [31:0] a, input logic [31:0] b);
    sb.push_back(model(s, a, b));
    is_signed = s; data1 = a; data2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; data1 = $urandom; data2 = $urandom; is_signed = $urandom_range(0, 1);
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  // Waits for done; optionally pulses a start with new operands after poke edges.
  task automatic wait_done(input string tag, input int lat, input int poke);
    int n;
    int busy_lo;
    exp_t e;
    busy_lo = 0;
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == poke) begin
        start = 1'b1; is_signed = 1'b1; data1 = 32'd1000; data2 = 32'd3;
      end else begin
        start = 1'b0;
      end
      if (done) break;
      if (!busy) busy_lo++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    chk({tag, "_busy_gaps"}, 32'(busy_lo), 32'd0);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    if (sb.size() == 0) begin
      vectors++; miscompares++;
      $error("FAIL %s_scoreboard: observed empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_q"}, quotient, e.q);
      chk({tag, "_r"}, remainder, e.r);
      chk({tag, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
      chk({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
    end
  endtask

  task automatic run(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b);
    start_op(s, a, b);
    wait_done(tag, (b == 0) ? 1 : 33, -1);
  endtask

  initial begin
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    run("divu_100_7", 1'b0, 32'd100, 32'd7);
    chk("divu_100_7_q_const", quotient, 32'd14);
    chk("divu_100_7_r_const", remainder, 32'd2);
    @(posedge clk); #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("hold_q", quotient, 32'd14);

    run("div_m7_2", 1'b1, -32'sd7, 32'd2);
    chk("div_m7_2_q_const", quotient, 32'hFFFF_FFFD);
    run("div_7_m2", 1'b1, 32'd7, -32'sd2);
    chk("div_7_m2_r_const", remainder, 32'd1);
    run("div_m7_m2", 1'b1, -32'sd7, -32'sd2);
    chk("div_m7_m2_q_const", quotient, 32'd3);
    run("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
    run("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_const", 32'(overflow), 32'd1);
    run("divu_5_9", 1'b0, 32'd5, 32'd9);
    run("divu_big", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("div_min_1", 1'b1, 32'h8000_0000, 32'd1);
    run("dbz_s", 1'b1, 32'h1234_5678, 32'd0);
    run("dbz_u", 1'b0, 32'h1234_5678, 32'd0);
    chk("dbz_u_r_const", remainder, 32'h1234_5678);
    run("after_dbz", 1'b0, 32'd9, 32'd3);
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom >> $urandom_range(0, 28);
      run("rand", 1'(i[0]), a, b);
    end

    // start mid-run is ignored; start in the done cycle is accepted
    start_op(1'b0, 32'd100, 32'd7);
    wait_done("ignored_start", 33, 5);
    start_op(1'b1, -32'sd1000, 32'd7);
    wait_done("back_to_back", 33, -1);

    // asynchronous reset mid-run
    start_op(1'b0, 32'd1000, 32'd7);
    void'(sb.pop_front());
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_q", quotient, 32'd0);
    chk("midrst_r", remainder, 32'd0);
    chk("midrst_flags", {30'd0, div_by_zero, overflow}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_done", 32'(done), 32'd0);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    run("post_rst", 1'b0, 32'd50, 32'd5);
    chk("post_rst_q_const", quotient, 32'd10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
